// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor front end: coin codes, decoder
// FSM encoding and the even-parity check used on received frames.
package coin_pkg;

  localparam logic [1:0] COIN_PENNY   = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ERR_WAIT
  } dec_state_e;

  // Even parity across the two code bits and the parity bit.
  function automatic logic parity_ok(input logic [1:0] code, input logic par);
    return ~(code[0] ^ code[1] ^ par);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for an asynchronous level input. Both flops reset to
// RST_VAL so an idle-high line produces no spurious edge on reset release.
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_frame_decoder.sv
// Recovers start/code[1:0]/parity/stop frames from the coin-acceptor line and
// emits one-cycle coin or frame-error pulses plus a saturating coin tally.
module coin_frame_decoder
  import coin_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serialIn,
  output logic               penny,
  output logic               nickel,
  output logic               dime,
  output logic               quarter,
  output logic               frame_error,
  output logic               busy,
  output logic [COUNT_W-1:0] coin_count
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

  logic             s;
  dec_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             bit_idx;
  logic [1:0]       code;
  logic             par;

  bit_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (serialIn),
    .q    (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 1'b0;
      code        <= '0;
      par         <= 1'b0;
      penny       <= 1'b0;
      nickel      <= 1'b0;
      dime        <= 1'b0;
      quarter     <= 1'b0;
      frame_error <= 1'b0;
      coin_count  <= '0;
    end else begin
      penny       <= 1'b0;
      nickel      <= 1'b0;
      dime        <= 1'b0;
      quarter     <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!s) state <= START;
        end

        // Re-check the start bit at mid-bit; a short low is a glitch.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= 1'b0;
            state   <= s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt           <= '0;
            code[bit_idx] <= s;
            bit_idx       <= ~bit_idx;
            if (bit_idx) state <= PARITY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            par   <= s;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (s && parity_ok(code, par)) begin
              unique case (code)
                COIN_PENNY:   penny   <= 1'b1;
                COIN_NICKEL:  nickel  <= 1'b1;
                COIN_DIME:    dime    <= 1'b1;
                COIN_QUARTER: quarter <= 1'b1;
              endcase
              if (coin_count != {COUNT_W{1'b1}}) coin_count <= coin_count + 1'b1;
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= ERR_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Wait for a full bit time of idle line so we never re-frame mid-frame.
        ERR_WAIT: begin
          if (!s) begin
            cnt <= '0;
          end else if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  a_pulse_exclusive: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({penny, nickel, dime, quarter, frame_error}));

endmodule
